// File: rtl/sm_regdump_pkg.sv
// Shared definitions for sm_regdump: FSM states, ASCII constants, line length.
// Line length depends on SM_REGDUMP_ADDR_EN (address prefix "AA:" when defined).
package sm_regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_LATCH,
        ST_SEND,
        ST_FINISH
    } state_t;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFF = 8'h37;

`ifdef SM_REGDUMP_ADDR_EN
    localparam int unsigned CHARS_PER_LINE = 12;
`else
    localparam int unsigned CHARS_PER_LINE = 9;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (ASCII_0 + {4'b0000, nib}) : (ASCII_A_OFF + {4'b0000, nib});
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// UART 8N1 transmitter with valid/ready handshake; CLK_DIV clock cycles per bit.
// ready is high in the last stop-bit cycle so back-to-back chars have no idle gap.
module sm_uart_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          bit_end;

    assign bit_end = active && (cnt == CNT_LAST);
    assign ready   = !active || (bit_end && (bit_idx == 4'd9));

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
            tx      <= 1'b0;
        end else if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                // shreg carries the stop bit behind the data, so bit 9 drives 1
                bit_idx <= bit_idx + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else if (active) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sm_regdump.sv
// sm_regdump: walks debug addresses FIRST_REG..LAST_REG and streams each value as a hex line over UART.
// Define SM_REGDUMP_ADDR_EN to prefix each line with the address as "AA:".
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_A  = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A   = 5'(LAST_REG);
    localparam logic [3:0] LAST_IDX = 4'(CHARS_PER_LINE - 1);

    state_t      state, state_n;
    logic [4:0]  addr;
    logic [31:0] snap;
    logic [3:0]  idx;
    logic        start_q;
    logic        done_q, done_n;
    logic        capture, inc_addr, idx_inc;
    logic        valid, ready;
    logic [7:0]  ch;
    logic [2:0]  nib_sel;

    assign regAddr = addr;
    assign busy    = (state != ST_IDLE);
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        valid    = 1'b0;
        capture  = 1'b0;
        inc_addr = 1'b0;
        idx_inc  = 1'b0;
        done_n   = 1'b0;
        case (state)
            ST_IDLE:   if (start_q) state_n = ST_SET;
            // snapshot is taken on the edge leaving SET, so LATCH already presents char 0
            ST_SET: begin
                state_n = ST_LATCH;
                capture = 1'b1;
            end
            ST_LATCH, ST_SEND: begin
                valid = 1'b1;
                if (ready) begin
                    if (idx == LAST_IDX) begin
                        if (addr < LAST_A) begin
                            inc_addr = 1'b1;
                            state_n  = ST_SET;
                        end else begin
                            state_n = ST_FINISH;
                        end
                    end else begin
                        idx_inc = 1'b1;
                        state_n = ST_SEND;
                    end
                end
            end
            ST_FINISH: begin
                if (ready) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // start is registered only while idle; pulses during a dump are dropped, not queued
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            addr    <= FIRST_A;
            snap    <= '0;
            idx     <= '0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start && (state == ST_IDLE) && !start_q;
            done_q  <= done_n;
            if (state == ST_IDLE && start_q) addr <= FIRST_A;
            else if (inc_addr)               addr <= addr + 5'd1;
            if (capture) begin
                snap <= regData;
                idx  <= '0;
            end else if (idx_inc) begin
                idx <= idx + 4'd1;
            end
        end
    end

`ifdef SM_REGDUMP_ADDR_EN
    always_comb begin
        nib_sel = 3'(idx - 4'd3);
        case (idx)
            4'd0:     ch = hex_ascii({3'b000, addr[4]});
            4'd1:     ch = hex_ascii(addr[3:0]);
            4'd2:     ch = ASCII_COLON;
            LAST_IDX: ch = ASCII_LF;
            default:  ch = hex_ascii(snap[{~nib_sel, 2'b00} +: 4]);
        endcase
    end
`else
    always_comb begin
        nib_sel = idx[2:0];
        ch      = (idx == LAST_IDX) ? ASCII_LF : hex_ascii(snap[{~nib_sel, 2'b00} +: 4]);
    end
`endif

    sm_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (ch),
        .valid (valid),
        .ready (ready),
        .tx    (tx)
    );

endmodule
